// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm status link: status bit positions inside the
// 4-bit frame, frame length, receiver FSM encoding, transmitter standby gap and
// the frame validity rule used by the panel-side receiver.
// -----------------------------------------------------------------------------
package alarm_pkg;

  localparam int BIT_ACTIVE = 0;
  localparam int BIT_ALARM  = 1;
  localparam int BIT_S1     = 2;
  localparam int BIT_S2     = 3;

  localparam int FRAME_BITS = 4;

  // Minimum idle cycles the transmitter leaves between frames.
  localparam int TX_STANDBY = 3;

  typedef logic [FRAME_BITS-1:0] frame_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } rx_state_e;

  // A siren without an armed system cannot come from a healthy transmitter.
  function automatic logic frame_is_valid(input frame_t f);
    return !(f[BIT_ALARM] && !f[BIT_ACTIVE]);
  endfunction

endpackage

// File: rtl/status_link_watchdog.sv
// -----------------------------------------------------------------------------
// status_link_watchdog
// Saturating cycle counter that measures time since the last valid frame.
// Ports:
//   clk_i      clock
//   rst_n_i    asynchronous active-low reset
//   clr_i      restart the count (a valid frame was just checked)
//   timeout_o  count has reached LINK_TIMEOUT (stays high until cleared)
// -----------------------------------------------------------------------------
module status_link_watchdog #(
  parameter int LINK_TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  output logic timeout_o
);

  localparam int CW = $clog2(LINK_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(LINK_TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = (cnt_q == LIMIT);

endmodule

// File: rtl/status_frame_rx.sv
// -----------------------------------------------------------------------------
// status_frame_rx
// Panel-side receiver for the 4-bit serial status frame. Deframes
// STATUS_SEND/STATUS_OUT, rejects invalid frames, requires MATCH_FRAMES
// identical consecutive valid frames before committing them to the indicator
// outputs, and tracks link health with a watchdog.
// Ports (all outputs registered):
//   CLK           forwarded transmitter clock
//   RST_N         asynchronous active-low reset
//   STATUS_SEND   one-cycle frame start strobe
//   STATUS_OUT    serial data, bit 3 first
//   ARMED/SIREN/SENSOR1/SENSOR2  committed frame bits 0/1/2/3
//   STATUS_VALID  committed outputs are current
//   LINK_OK       valid frame seen within LINK_TIMEOUT cycles
//   NEW_STATUS    one-cycle pulse when a changed value is committed
//   FRAME_ERR     one-cycle pulse when a frame is rejected or aborted
// -----------------------------------------------------------------------------
module status_frame_rx
  import alarm_pkg::*;
#(
  parameter int MATCH_FRAMES = 2,
  parameter int LINK_TIMEOUT = 64
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic STATUS_SEND,
  input  logic STATUS_OUT,
  output logic ARMED,
  output logic SIREN,
  output logic SENSOR1,
  output logic SENSOR2,
  output logic STATUS_VALID,
  output logic LINK_OK,
  output logic NEW_STATUS,
  output logic FRAME_ERR
);

  localparam logic [2:0] MATCH_C = 3'(MATCH_FRAMES);

  rx_state_e  state_q, state_d;
  logic [1:0] bitcnt_q, bitcnt_d;
  frame_t     shreg_q, shreg_d;
  frame_t     cand_q, cand_d;
  frame_t     com_q, com_d;
  logic [2:0] match_q, match_d;
  logic       svalid_q, svalid_d;
  logic       link_q, link_d;
  logic       newp_q, newp_d;
  logic       err_q, err_d;
  logic       chk_valid;
  logic       timeout;

  status_link_watchdog #(
    .LINK_TIMEOUT(LINK_TIMEOUT)
  ) u_wdog (
    .clk_i    (CLK),
    .rst_n_i  (RST_N),
    .clr_i    (chk_valid),
    .timeout_o(timeout)
  );

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    cand_d    = cand_q;
    com_d     = com_q;
    match_d   = match_q;
    svalid_d  = svalid_q;
    link_d    = link_q;
    newp_d    = 1'b0;
    err_d     = 1'b0;
    chk_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (STATUS_SEND) begin
          state_d  = SHIFT;
          bitcnt_d = '0;
        end
      end

      SHIFT: begin
        if (STATUS_SEND) begin
          // A strobe inside a frame is a fresh t0: drop the partial frame.
          err_d    = 1'b1;
          bitcnt_d = '0;
        end else begin
          shreg_d  = {shreg_q[FRAME_BITS-2:0], STATUS_OUT};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 2'd3) begin
            state_d = CHECK;
          end
        end
      end

      CHECK: begin
        // A back-to-back strobe is honoured while this frame is evaluated.
        state_d  = STATUS_SEND ? SHIFT : IDLE;
        bitcnt_d = '0;
        if (frame_is_valid(shreg_q)) begin
          chk_valid = 1'b1;
          link_d    = 1'b1;
          if (shreg_q == cand_q) begin
            match_d = (match_q == MATCH_C) ? match_q : match_q + 1'b1;
          end else begin
            cand_d  = shreg_q;
            match_d = 3'd1;
          end
          if (match_d == MATCH_C) begin
            newp_d   = !svalid_q || (com_q != shreg_q);
            com_d    = shreg_q;
            svalid_d = 1'b1;
          end
        end else begin
          err_d   = 1'b1;
          match_d = '0;
          cand_d  = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A valid check on the timeout edge keeps the link alive.
    if (timeout && !chk_valid) begin
      link_d   = 1'b0;
      svalid_d = 1'b0;
      com_d    = '0;
      match_d  = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      cand_q   <= '0;
      com_q    <= '0;
      match_q  <= '0;
      svalid_q <= 1'b0;
      link_q   <= 1'b0;
      newp_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      cand_q   <= cand_d;
      com_q    <= com_d;
      match_q  <= match_d;
      svalid_q <= svalid_d;
      link_q   <= link_d;
      newp_q   <= newp_d;
      err_q    <= err_d;
    end
  end

  // Shift register only ever reaches CHECK fully overwritten, so no reset.
  always_ff @(posedge CLK) begin
    shreg_q <= shreg_d;
  end

  assign ARMED        = com_q[BIT_ACTIVE];
  assign SIREN        = com_q[BIT_ALARM];
  assign SENSOR1      = com_q[BIT_S1];
  assign SENSOR2      = com_q[BIT_S2];
  assign STATUS_VALID = svalid_q;
  assign LINK_OK      = link_q;
  assign NEW_STATUS   = newp_q;
  assign FRAME_ERR    = err_q;

endmodule

// File: tb/tb_status_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_status_frame_rx
// Directed scenarios followed by randomized frame traffic, every cycle compared
// against a frame-level behavioural model of the receiver.
// -----------------------------------------------------------------------------
module tb_status_frame_rx;
  import alarm_pkg::*;

  localparam int M  = 2;
  localparam int LT = 64;

  logic CLK = 1'b0;
  logic RST_N;
  logic STATUS_SEND;
  logic STATUS_OUT;
  logic ARMED, SIREN, SENSOR1, SENSOR2;
  logic STATUS_VALID, LINK_OK, NEW_STATUS, FRAME_ERR;

  status_frame_rx #(
    .MATCH_FRAMES(M),
    .LINK_TIMEOUT(LT)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .STATUS_SEND (STATUS_SEND),
    .STATUS_OUT  (STATUS_OUT),
    .ARMED       (ARMED),
    .SIREN       (SIREN),
    .SENSOR1     (SENSOR1),
    .SENSOR2     (SENSOR2),
    .STATUS_VALID(STATUS_VALID),
    .LINK_OK     (LINK_OK),
    .NEW_STATUS  (NEW_STATUS),
    .FRAME_ERR   (FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [3:0] e_com;
  logic       e_sv, e_link, e_newp, e_err;
  logic [3:0] cand;
  int         mcount;
  int         since;
  int         left;
  logic [3:0] acc;
  bit         pend_chk;
  logic [3:0] pend_val;

  int nsp;   // NEW_STATUS pulses observed
  int erp;   // FRAME_ERR pulses observed

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_com = '0; e_sv = 0; e_link = 0; e_newp = 0; e_err = 0;
    cand = '0; mcount = 0; since = 0; left = 0; acc = '0;
    pend_chk = 0; pend_val = '0;
  endtask

  // Effect of one clock edge on the model, given the inputs seen at that edge.
  task automatic model_edge(input bit send, input bit data);
    bit chkf, vld;
    logic [3:0] v;
    chkf = pend_chk; v = pend_val; pend_chk = 0;
    e_err = 0; e_newp = 0;
    if (send) begin
      if (left > 0) e_err = 1;
      left = 4; acc = '0;
    end else if (left > 0) begin
      acc = {acc[2:0], data};
      left--;
      if (left == 0) begin pend_chk = 1; pend_val = acc; end
    end
    vld = chkf && !(v[1] && !v[0]);
    if (chkf && !vld) begin
      e_err = 1; mcount = 0; cand = '0;
    end
    if (vld) begin
      e_link = 1;
      if (v == cand) mcount = (mcount < M) ? mcount + 1 : M;
      else begin cand = v; mcount = 1; end
      if (mcount == M) begin
        e_newp = !e_sv || (e_com != v);
        e_com = v; e_sv = 1;
      end
    end
    if (!vld && since == LT) begin
      e_link = 0; e_sv = 0; e_com = '0; mcount = 0;
    end
    since = vld ? 0 : ((since < LT) ? since + 1 : since);
  endtask

  task automatic check_all();
    chk(ARMED,        e_com[0], "ARMED");
    chk(SIREN,        e_com[1], "SIREN");
    chk(SENSOR1,      e_com[2], "SENSOR1");
    chk(SENSOR2,      e_com[3], "SENSOR2");
    chk(STATUS_VALID, e_sv,     "STATUS_VALID");
    chk(LINK_OK,      e_link,   "LINK_OK");
    chk(NEW_STATUS,   e_newp,   "NEW_STATUS");
    chk(FRAME_ERR,    e_err,    "FRAME_ERR");
  endtask

  task automatic step(input bit send, input bit data);
    STATUS_SEND = send;
    STATUS_OUT  = data;
    @(posedge CLK);
    model_edge(send, data);
    #1;
    check_all();
    if (NEW_STATUS === 1'b1) nsp++;
    if (FRAME_ERR === 1'b1) erp++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  task automatic send_frame(input logic [3:0] v, input int gap);
    step(1, 0);
    for (int i = 3; i >= 0; i--) step(0, v[i]);
    idle(gap);
  endtask

  task automatic zero_outputs(input string tag);
    chk({ARMED, SIREN, SENSOR1, SENSOR2, STATUS_VALID, LINK_OK, NEW_STATUS, FRAME_ERR},
        32'h0, tag);
  endtask

  initial begin
    logic [3:0] v, last;
    int gap;
    RST_N = 1'b0; STATUS_SEND = 1'b0; STATUS_OUT = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    zero_outputs("reset_state");
    #3 RST_N = 1'b1;
    idle(3);

    // Two matching 0001 frames commit ARMED.
    nsp = 0;
    send_frame(4'b0001, TX_STANDBY);
    chk(STATUS_VALID, 1'b0, "t1_no_commit_after_first");
    send_frame(4'b0001, 0);
    step(0, 0);   // t5 of the second frame
    chk(NEW_STATUS, 1'b1, "t1_newstatus_at_t5");
    idle(TX_STANDBY - 1);
    chk(ARMED, 1'b1, "t1_armed");
    chk(SIREN, 1'b0, "t1_siren");
    chk(STATUS_VALID, 1'b1, "t1_valid");
    chk(nsp, 1, "t1_one_pulse");

    // 0001, 0011, 0011: commit only on the third frame.
    nsp = 0;
    send_frame(4'b0001, TX_STANDBY + 1);
    send_frame(4'b0011, TX_STANDBY + 1);
    chk(SIREN, 1'b0, "t2_siren_not_yet");
    send_frame(4'b0011, TX_STANDBY + 1);
    chk(SIREN, 1'b1, "t2_siren");
    chk(ARMED, 1'b1, "t2_armed");
    chk(nsp, 1, "t2_one_pulse");

    // Invalid 0010 between 0001 frames resets matching.
    erp = 0;
    send_frame(4'b0001, TX_STANDBY + 1);
    send_frame(4'b0010, TX_STANDBY + 1);
    chk(erp, 1, "t3_frame_err");
    send_frame(4'b0001, TX_STANDBY + 1);
    chk(SIREN, 1'b1, "t3_no_commit_yet");
    send_frame(4'b0001, TX_STANDBY + 1);
    chk(SIREN, 1'b0, "t3_commit_0001");

    // Strobe re-asserted after two bits, then 0101 from the restart.
    erp = 0;
    step(1, 0); step(0, 1); step(0, 1);
    send_frame(4'b0101, TX_STANDBY + 1);
    chk(erp, 1, "t4_abort_err");
    send_frame(4'b0101, TX_STANDBY + 1);
    chk(SENSOR1, 1'b1, "t4_sensor1");
    chk(SIREN, 1'b0, "t4_siren");

    // Link loss and recovery.
    send_frame(4'b0001, TX_STANDBY);
    send_frame(4'b0001, 40);
    chk(LINK_OK, 1'b1, "t5_link_alive");
    idle(40);
    chk(LINK_OK, 1'b0, "t5_link_lost");
    chk(STATUS_VALID, 1'b0, "t5_valid_dropped");
    chk(ARMED, 1'b0, "t5_armed_forced");
    send_frame(4'b1101, TX_STANDBY);
    chk(LINK_OK, 1'b1, "t5_link_back");
    chk(STATUS_VALID, 1'b0, "t5_not_committed");
    send_frame(4'b1101, TX_STANDBY);
    chk({SENSOR2, SENSOR1, SIREN, ARMED}, 4'b1101, "t5_committed");
    chk(STATUS_VALID, 1'b1, "t5_valid");

    // Asynchronous reset in the middle of a frame.
    step(1, 0); step(0, 1); step(0, 0);
    #2 RST_N = 1'b0;
    #1;
    zero_outputs("t6_async_reset");
    model_reset();
    STATUS_SEND = 1'b0;
    @(posedge CLK);
    #3 RST_N = 1'b1;
    idle(2);
    send_frame(4'b1001, TX_STANDBY);
    send_frame(4'b1001, TX_STANDBY);
    chk(SENSOR2, 1'b1, "t6_sensor2");
    chk(ARMED, 1'b1, "t6_armed");

    // Randomized traffic: repeats, new values, aborts, back-to-back, timeouts.
    last = 4'b0001;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 99) < 10) begin
        step(1, 0);
        for (int k = 0; k < int'($urandom_range(0, 3)); k++) step(0, 1'($urandom));
      end
      v = ($urandom_range(0, 99) < 65) ? last : 4'($urandom_range(0, 15));
      last = v;
      gap = ($urandom_range(0, 99) < 4) ? 70 : int'($urandom_range(0, 6));
      send_frame(v, gap);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
